sine_ctrl_master: RTL and testbench

- Avalon-MM initiator that programs and services the sine-wave CSR slave with no processor involved.
- On start it writes the frequency word, enables the interrupt and sets run. On each irq it reads the current sample, returns it to local logic and clears the irq. On stop it shuts the generator down.
- Sits between local control logic and the slave's ChipSelect/Write/Read/Address/WriteData/ReadData/irq pins.

---
 rtl/sine_ctrl_master.sv | 177 +++++++++++++++++
 tb/tb_sine_ctrl_master.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sine_ctrl_master.sv
// sine_ctrl_master: Avalon-MM initiator that programs the sine CSR slave and services its irq.
// Define SINE_CTRL_MASTER_PEAK_EN to add sample_min/sample_max tracking outputs.
module sine_ctrl_master #(
  parameter int READ_LATENCY = 1,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             start,
  input  logic             stop,
  input  logic             fcw_update,
  input  logic [7:0]       cfg_fcw,
  output logic             ChipSelect,
  output logic             Write,
  output logic             Read,
  output logic [1:0]       Address,
  output logic [31:0]      WriteData,
  input  logic [31:0]      ReadData,
  input  logic             irq,
  output logic [9:0]       sample,
  output logic             sample_valid,
  output logic [CNT_W-1:0] sample_count,
  output logic             busy
`ifdef SINE_CTRL_MASTER_PEAK_EN
  ,
  output logic [9:0]       sample_min,
  output logic [9:0]       sample_max
`endif
);
  typedef enum logic [3:0] {
    IDLE, W_FCW, W_IEN, W_RUN, ACTIVE, R_DATA, R_WAIT, W_CLR, W_CLR_GAP, S_RUN0, S_IEN0
  } state_t;
  state_t state_q, state_d;
  logic init_q, init_d, stop_pend_q, stop_pend_d, cap, clr;
  logic [1:0] wait_cnt_q, wait_cnt_d;
  logic cs_q, cs_d, wr_q, wr_d, rd_q, rd_d, valid_q, valid_d, busy_q, busy_d;
  logic [1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [9:0] sample_q, sample_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic unused_rd;
  assign unused_rd = ^ReadData[31:10];
  // ReadData is valid READ_LATENCY cycles after the read command, so capture lands on that cycle
  assign cap = (READ_LATENCY == 0) ? (state_q == R_DATA)
             : (state_q == R_WAIT && wait_cnt_q == 2'(READ_LATENCY - 1));
  assign clr = (state_q == IDLE) && start;
  always_comb begin
    state_d = state_q;
    init_d = init_q;
    stop_pend_d = stop_pend_q;
    wait_cnt_d = '0;
    if (stop && (state_q == R_DATA || state_q == R_WAIT || state_q == W_CLR || state_q == W_CLR_GAP))
      stop_pend_d = 1'b1;
    case (state_q)
      IDLE: if (start) begin
        state_d = W_FCW;
        init_d = 1'b1;
        stop_pend_d = 1'b0;
      end
      W_FCW: begin
        state_d = init_q ? W_IEN : ACTIVE;
        init_d = 1'b0;
      end
      W_IEN: state_d = W_RUN;
      W_RUN: state_d = ACTIVE;
      ACTIVE: if (stop || stop_pend_q) begin
        state_d = S_RUN0;
        stop_pend_d = 1'b0;
      end else if (fcw_update) state_d = W_FCW;
      else if (irq) state_d = R_DATA;
      R_DATA: state_d = cap ? W_CLR : R_WAIT;
      R_WAIT: begin
        wait_cnt_d = wait_cnt_q + 2'd1;
        if (cap) state_d = W_CLR;
      end
      W_CLR: state_d = W_CLR_GAP;
      W_CLR_GAP: state_d = ACTIVE;
      S_RUN0: state_d = S_IEN0;
      S_IEN0: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Bus strobes are registered from the next state so they line up with that state's cycle
  always_comb begin
    cs_d = 1'b1;
    wr_d = 1'b1;
    rd_d = 1'b0;
    addr_d = 2'd0;
    wdata_d = 32'd0;
    case (state_d)
      W_FCW: begin
        addr_d = 2'd1;
        wdata_d = {24'd0, cfg_fcw};
      end
      W_IEN: begin
        addr_d = 2'd3;
        wdata_d = 32'd1;
      end
      W_RUN: wdata_d = 32'd1;
      R_DATA: begin
        wr_d = 1'b0;
        rd_d = 1'b1;
        addr_d = 2'd2;
      end
      W_CLR: begin
        addr_d = 2'd3;
        wdata_d = 32'd3;
      end
      S_RUN0: addr_d = 2'd0;
      S_IEN0: addr_d = 2'd3;
      default: begin
        cs_d = 1'b0;
        wr_d = 1'b0;
      end
    endcase
  end
  assign sample_d = cap ? ReadData[9:0] : sample_q;
  assign valid_d = cap;
  assign count_d = clr ? '0 : cap ? count_q + 1'b1 : count_q;
  assign busy_d = state_d != IDLE;
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      init_q <= 1'b0;
      stop_pend_q <= 1'b0;
      wait_cnt_q <= '0;
      cs_q <= 1'b0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      sample_q <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q <= init_d;
      stop_pend_q <= stop_pend_d;
      wait_cnt_q <= wait_cnt_d;
      cs_q <= cs_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      sample_q <= sample_d;
      valid_q <= valid_d;
      count_q <= count_d;
      busy_q <= busy_d;
    end
  end
  assign ChipSelect = cs_q;
  assign Write = wr_q;
  assign Read = rd_q;
  assign Address = addr_q;
  assign WriteData = wdata_q;
  assign sample = sample_q;
  assign sample_valid = valid_q;
  assign sample_count = count_q;
  assign busy = busy_q;
`ifdef SINE_CTRL_MASTER_PEAK_EN
  logic [9:0] min_q, min_d, max_q, max_d;
  assign min_d = clr ? 10'h3FF : (cap && ReadData[9:0] < min_q) ? ReadData[9:0] : min_q;
  assign max_d = clr ? 10'h000 : (cap && ReadData[9:0] > max_q) ? ReadData[9:0] : max_q;
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      min_q <= 10'h3FF;
      max_q <= 10'h000;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end
  assign sample_min = min_q;
  assign sample_max = max_q;
`endif
endmodule

// File: tb/tb_sine_ctrl_master.sv
// tb_sine_ctrl_master: scoreboard bench for sine_ctrl_master with a transaction-level slave model.
module tb_sine_ctrl_master;
  localparam int RL = 1;
  localparam int CW = 4;
  logic Clk = 1'b0, ResetN = 1'b0, start = 1'b0, stop = 1'b0, fcw_update = 1'b0;
  logic [7:0] cfg_fcw = 8'h0;
  logic ChipSelect, Write, Read, busy, sample_valid;
  logic [1:0] Address;
  logic [31:0] WriteData, ReadData;
  logic irq = 1'b0, irq_req = 1'b0;
  logic [9:0] sample;
  logic [CW-1:0] sample_count;
  logic [31:0] slave_word = 32'h0;
  logic [31:0] pipe [0:3];
  int cyc = 0, checks = 0, errors = 0, n_samp = 0, pmin = 1023, pmax = 0;
  logic idle_chk = 1'b0;
`ifdef SINE_CTRL_MASTER_PEAK_EN
  logic [9:0] sample_min, sample_max;
`endif
  typedef struct { logic wr; logic [1:0] addr; logic [31:0] data; int cyc; } bus_t;
  typedef struct { logic [9:0] v; int cnt; int cyc; } smp_t;
  bus_t q_bus[$];
  smp_t q_smp[$];

  sine_ctrl_master #(.READ_LATENCY(RL), .CNT_W(CW)) dut (
    .Clk(Clk), .ResetN(ResetN), .start(start), .stop(stop), .fcw_update(fcw_update),
    .cfg_fcw(cfg_fcw), .ChipSelect(ChipSelect), .Write(Write), .Read(Read),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .irq(irq),
    .sample(sample), .sample_valid(sample_valid), .sample_count(sample_count), .busy(busy)
`ifdef SINE_CTRL_MASTER_PEAK_EN
    , .sample_min(sample_min), .sample_max(sample_max)
`endif
  );

  always #5 Clk = ~Clk;

  // Slave side: read data pipeline and level irq cleared by a write of bit1 to register 3
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    pipe[0] <= slave_word;
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    if (irq_req) irq <= 1'b1;
    else if (ChipSelect && Write && Address == 2'd3 && WriteData[1]) irq <= 1'b0;
  end
  assign ReadData = (RL == 0) ? slave_word : pipe[(RL == 0) ? 0 : RL - 1];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge Clk) if (ResetN) begin
    if (ChipSelect || Write || Read || Address != 2'd0 || WriteData != 32'd0) begin
      if (q_bus.size() == 0) chk("bus_unexpected", {ChipSelect, Write, Read}, 3'b000);
      else begin
        bus_t e;
        e = q_bus.pop_front();
        chk("bus_one_strobe", {ChipSelect, Write ^ Read}, 2'b11);
        chk("bus_write", Write, e.wr);
        chk("bus_addr", Address, e.addr);
        chk("bus_wdata", WriteData, e.data);
        chk("busy_in_access", busy, 1'b1);
        if (e.cyc >= 0) chk("bus_cycle", cyc, e.cyc);
      end
    end
    if (sample_valid) begin
      if (q_smp.size() == 0) chk("sample_unexpected", sample_valid, 1'b0);
      else begin
        smp_t s;
        s = q_smp.pop_front();
        chk("sample_value", sample, s.v);
        chk("sample_count", sample_count, s.cnt);
        chk("sample_cycle", cyc, s.cyc);
      end
    end
    if (idle_chk) chk("busy_idle", busy, 1'b0);
  end

  function automatic bus_t bt(input logic wr, input logic [1:0] a, input logic [31:0] d, input int c);
    bus_t b;
    b.wr = wr; b.addr = a; b.data = d; b.cyc = c;
    return b;
  endfunction

  task automatic do_start(input logic [7:0] fcw);
    @(negedge Clk);
    cfg_fcw = fcw;
    start = 1'b1;
    q_bus.push_back(bt(1'b1, 2'd1, {24'd0, fcw}, cyc + 1));
    q_bus.push_back(bt(1'b1, 2'd3, 32'd1, cyc + 2));
    q_bus.push_back(bt(1'b1, 2'd0, 32'd1, cyc + 3));
    n_samp = 0; pmin = 1023; pmax = 0;
    @(negedge Clk);
    start = 1'b0;
  endtask

  // Optionally pair the irq with an fcw rewrite (which goes first) and/or a stop that lands in the read wait.
  task automatic do_irq(input logic [9:0] v, input bit with_fcw, input logic [7:0] fcw, input bit with_stop);
    int ic, d;
    @(negedge Clk);
    slave_word = {$urandom_range(0, 32'h3FFFFF) , v};
    irq_req = 1'b1;
    d = with_fcw ? 1 : 0;
    if (with_fcw) begin
      fcw_update = 1'b1;
      cfg_fcw = fcw;
      q_bus.push_back(bt(1'b1, 2'd1, {24'd0, fcw}, cyc + 1));
    end
    ic = cyc + 1;
    n_samp++;
    if (int'(v) < pmin) pmin = int'(v);
    if (int'(v) > pmax) pmax = int'(v);
    q_bus.push_back(bt(1'b0, 2'd2, 32'd0, ic + 1 + d));
    q_bus.push_back(bt(1'b1, 2'd3, 32'd3, ic + 2 + RL + d));
    q_smp.push_back('{v, n_samp % (1 << CW), ic + 2 + RL + d});
    @(negedge Clk);
    irq_req = 1'b0;
    fcw_update = 1'b0;
    if (with_stop) begin
      repeat (2) @(negedge Clk);
      stop = 1'b1;
      q_bus.push_back(bt(1'b1, 2'd0, 32'd0, -1));
      q_bus.push_back(bt(1'b1, 2'd3, 32'd0, -1));
      @(negedge Clk);
      stop = 1'b0;
    end
  endtask

  task automatic do_fcw(input logic [7:0] fcw);
    @(negedge Clk);
    fcw_update = 1'b1;
    cfg_fcw = fcw;
    q_bus.push_back(bt(1'b1, 2'd1, {24'd0, fcw}, cyc + 1));
    @(negedge Clk);
    fcw_update = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((q_bus.size() != 0 || q_smp.size() != 0) && n < 300) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_in_time", n < 300, 1'b1);
    repeat (3) @(negedge Clk);
  endtask

  task automatic do_stop_idle;
    @(negedge Clk);
    stop = 1'b1;
    q_bus.push_back(bt(1'b1, 2'd0, 32'd0, cyc + 1));
    q_bus.push_back(bt(1'b1, 2'd3, 32'd0, cyc + 2));
    @(negedge Clk);
    stop = 1'b0;
    drain();
    idle_chk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    idle_chk = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {ChipSelect, Write, Read, Address, WriteData, sample, sample_valid, sample_count, busy}, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clk);
    chk_zero("reset_outputs");
`ifdef SINE_CTRL_MASTER_PEAK_EN
    chk("reset_peak", {sample_min, sample_max}, {10'h3FF, 10'h000});
`endif
    ResetN = 1'b1;
    @(negedge Clk);
    do_start(8'h25);
    drain();
    do_irq(10'h2A7, 1'b0, 8'h0, 1'b0);
    drain();
    do_irq(10'h155, 1'b1, 8'h80, 1'b0);
    drain();
    for (int k = 0; k < 10; k++) begin
      int sel;
      repeat ($urandom_range(0, 4)) @(negedge Clk);
      sel = $urandom_range(0, 2);
      if (sel == 0) do_fcw(8'($urandom));
      else do_irq(10'($urandom), sel == 2, 8'($urandom), 1'b0);
      drain();
    end
    do_irq(10'h0AB, 1'b0, 8'h0, 1'b1);
    drain();
    idle_chk = 1'b1;
    @(negedge Clk);
    idle_chk = 1'b0;
    do_start(8'h11);
    @(posedge Clk);
    #2 ResetN = 1'b0;
    #1 chk_zero("async_reset_mid_write");
    q_bus.delete();
    repeat (2) @(negedge Clk);
    chk_zero("async_reset_held");
    ResetN = 1'b1;
    repeat (2) @(negedge Clk);
    do_start(8'h3C);
    drain();
    do_irq(10'h010, 1'b0, 8'h0, 1'b0);
    drain();
    do_irq(10'h3F0, 1'b0, 8'h0, 1'b0);
    drain();
    do_irq(10'h100, 1'b0, 8'h0, 1'b0);
    drain();
`ifdef SINE_CTRL_MASTER_PEAK_EN
    chk("peak_min", sample_min, 10'(pmin));
    chk("peak_max", sample_max, 10'(pmax));
`endif
    for (int k = 0; k < 14; k++) begin
      do_irq(10'($urandom_range(16, 1008)), 1'b0, 8'h0, 1'b0);
      drain();
    end
    chk("count_wrapped", sample_count, 1);
`ifdef SINE_CTRL_MASTER_PEAK_EN
    chk("peak_min_end", sample_min, 10'h010);
    chk("peak_max_end", sample_max, 10'h3F0);
`endif
    do_stop_idle();
    chk("bus_queue_empty", q_bus.size(), 0);
    chk("sample_queue_empty", q_smp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
